// File: rtl/alu_seq_ctrl.sv
// Command sequencer in front of the shared 8-bit ALU: single-cycle ops, CMP, and an 8-cycle shift-add MUL.
// Optional: define ALU_SEQ_MUL_ZERO_SKIP_EN to short-circuit MUL with a zero operand.
module alu_seq_ctrl #(
    parameter logic [3:0] OP_MUL = 4'hA,
    parameter logic [3:0] OP_CMP = 4'hB
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_s,
    input  logic [7:0]  alu_out,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_c,
    input  logic        alu_v
);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t      state;
    logic [3:0]  op_r;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [7:0]  p_r;
    logic [7:0]  q_r;
    logic [2:0]  cnt;
    logic [15:0] prod_nxt;
    logic        mul_zero;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= 4'h9) || (op == OP_CMP);
    endfunction

`ifdef ALU_SEQ_MUL_ZERO_SKIP_EN
    assign mul_zero = (cmd_a == 8'h00) || (cmd_b == 8'h00);
`else
    assign mul_zero = 1'b0;
`endif

    assign cmd_ready = (state == IDLE);

    // The ALU carry-out becomes bit 7 of P as the 9-bit partial sum shifts right.
    assign prod_nxt = {alu_c, alu_out, q_r[7:1]};

    always_comb begin
        alu_a = 8'h00;
        alu_b = 8'h00;
        alu_s = 4'h0;
        case (state)
            EXEC: begin
                alu_a = a_r;
                alu_b = b_r;
                alu_s = (op_r == OP_CMP) ? 4'h1 : op_r;
            end
            MUL: begin
                alu_a = p_r;
                alu_b = q_r[0] ? a_r : 8'h00;
                alu_s = 4'h0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_r      <= 4'h0;
            a_r       <= 8'h00;
            b_r       <= 8'h00;
            p_r       <= 8'h00;
            q_r       <= 8'h00;
            cnt       <= 3'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 16'h0000;
            rsp_flags <= 4'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_r <= cmd_op;
                        a_r  <= cmd_a;
                        b_r  <= cmd_b;
                        if (is_alu_op(cmd_op)) begin
                            state <= EXEC;
                        end else if (cmd_op == OP_MUL) begin
                            if (mul_zero) begin
                                state     <= DONE;
                                rsp_valid <= 1'b1;
                                rsp_data  <= 16'h0000;
                                rsp_flags <= 4'b1000;
                                rsp_err   <= 1'b0;
                            end else begin
                                state <= MUL;
                                p_r   <= 8'h00;
                                q_r   <= cmd_b;
                                cnt   <= 3'd0;
                            end
                        end else begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_data  <= 16'h0000;
                            rsp_flags <= 4'h0;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    state     <= DONE;
                    rsp_valid <= 1'b1;
                    rsp_data  <= {8'h00, (op_r == OP_CMP) ? a_r : alu_out};
                    rsp_flags <= {alu_z, alu_n, alu_c, alu_v};
                    rsp_err   <= 1'b0;
                end
                MUL: begin
                    {p_r, q_r} <= prod_nxt;
                    cnt        <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_data  <= prod_nxt;
                        rsp_flags <= {prod_nxt == 16'h0000, prod_nxt[15], prod_nxt[15:8] != 8'h00, 1'b0};
                        rsp_err   <= 1'b0;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
